// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown timer and its prescaler.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_CNT_W    = 4;
    localparam int DEF_TICK_DIV = 1000;
    localparam int PRESC_W      = $clog2(DEF_TICK_DIV);

    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 divider; tick is combinational on the last phase while enabled.
module tick_prescaler
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            PW   = presc_width(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    // clr beats en so a load landing on a tick phase restarts the period
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer_p.sv
// Programmable countdown timer with pause, one-shot/auto-reload and expiry flags.
// Define COUNTDOWN_WARN_EN to add the registered low-count `warn` output.
module countdown_timer_p
    import countdown_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TICK_DIV = DEF_TICK_DIV
`ifdef COUNTDOWN_WARN_EN
    ,
    parameter int WARN_TH  = 3
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             tick,
    output logic             expire,
    output logic             over
`ifdef COUNTDOWN_WARN_EN
    ,
    output logic             warn
`endif
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             running_q, running_d;
    logic             expire_q, expire_d;
    logic             over_q, over_d;
    logic             presc_clr, presc_en, tick_w;

    assign presc_en = (state_q == RUN) && !pause;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (tick_w)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        over_d    = over_q;
        expire_d  = 1'b0;
        presc_clr = load;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            over_d   = 1'b0;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !pause) begin
                        if (count_q == '0) begin
                            state_d  = DONE;
                            expire_d = 1'b1;
                            over_d   = 1'b1;
                        end else begin
                            state_d   = RUN;
                            presc_clr = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (tick_w) begin
                        if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else begin
                            expire_d = 1'b1;
                            over_d   = 1'b1;
                            // A zero reload value would park RUN at 0, so treat it as one-shot
                            if (auto_reload && (reload_q != '0)) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = DONE;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (start && !pause) begin
                        state_d = RUN;
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            running_q <= 1'b0;
            expire_q  <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            running_q <= running_d;
            expire_q  <= expire_d;
            over_q    <= over_d;
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign tick    = tick_w;
    assign expire  = expire_q;
    assign over    = over_q;

`ifdef COUNTDOWN_WARN_EN
    localparam logic [CNT_W-1:0] WARN_V = CNT_W'(WARN_TH);

    logic warn_q, warn_d;

    always_comb begin
        warn_d = ((state_q == RUN) || (state_q == PAUSE)) && (count_q != '0) && (count_q <= WARN_V);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign warn = warn_q;
`endif

endmodule

// File: tb/tb_countdown_timer_p.sv
// Randomised and directed bench for countdown_timer_p against a behavioural timer model.
module tb_countdown_timer_p;

    localparam int TD = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [CW-1:0] load_val = '0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          auto_reload = 1'b0;
    logic [CW-1:0] count;
    logic          running, tick, expire, over;
`ifdef COUNTDOWN_WARN_EN
    logic          warn;
`endif

    int total = 0;
    int bad   = 0;

    countdown_timer_p #(
        .CNT_W    (CW),
        .TICK_DIV (TD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .pause       (pause),
        .auto_reload (auto_reload),
        .count       (count),
        .running     (running),
        .tick        (tick),
        .expire      (expire),
        .over        (over)
`ifdef COUNTDOWN_WARN_EN
        ,
        .warn        (warn)
`endif
    );

    always #5 clk = ~clk;

    // Model: remaining value, reload value, activity flags and cycles left until the next step
    logic [CW-1:0] m_count, m_reload;
    logic          m_run, m_paused, m_done, m_over, m_expire, m_tick;
    int            m_left;
    logic          obs_tick;

    function automatic void model_reset();
        m_count = '0; m_reload = '0; m_run = 0; m_paused = 0; m_done = 0;
        m_over = 0; m_expire = 0; m_tick = 0; m_left = TD;
    endfunction

    function automatic void model_step(input logic l, input logic [CW-1:0] lv,
                                       input logic s, input logic p, input logic ar);
        logic ex;
        ex = 0;
        if (l) begin
            m_count = lv; m_reload = lv; m_over = 0;
            m_run = 0; m_paused = 0; m_done = 0; m_left = TD;
        end else if (m_run) begin
            if (p) begin
                m_run = 0; m_paused = 1;
            end else if (m_left == 1) begin
                m_left = TD;
                if (m_count > 1) begin
                    m_count = m_count - 1;
                end else begin
                    ex = 1; m_over = 1;
                    if (ar && m_reload != 0) m_count = m_reload;
                    else begin m_count = 0; m_run = 0; m_done = 1; end
                end
            end else begin
                m_left = m_left - 1;
            end
        end else if (m_paused) begin
            if (s && !p) begin m_run = 1; m_paused = 0; end
        end else if (!m_done) begin
            if (s && !p) begin
                if (m_count == 0) begin m_done = 1; ex = 1; m_over = 1; end
                else begin m_run = 1; m_left = TD; end
            end
        end
        m_expire = ex;
    endfunction

    task automatic drive(input logic l, input logic [CW-1:0] lv, input logic s,
                         input logic p, input logic ar);
        load = l; load_val = lv; start = s; pause = p; auto_reload = ar;
        #1;
        obs_tick = tick;
        m_tick = m_run && !p && (m_left == 1);
        @(posedge clk);
        model_step(l, lv, s, p, ar);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({count, running, tick, expire, over} !== '0) begin
            bad++;
            $display("FAIL reset_hold got=%b want=0", {count, running, tick, expire, over});
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        total++;
        if ({count, running, expire, over, obs_tick} !== {m_count, m_run, m_expire, m_over, m_tick}) begin
            bad++;
            $display("FAIL reset_release got=%b want=%b", {count, running, expire, over, obs_tick},
                     {m_count, m_run, m_expire, m_over, m_tick});
        end
    endtask

    task automatic test_oneshot();
        int ticks = 0, exps = 0;
        drive(1, 3, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            drive(0, 3, 1, 0, 0);
            ticks += int'(obs_tick);
            exps  += int'(expire);
            total++;
            if ({count, running, expire, over, obs_tick} !== {m_count, m_run, m_expire, m_over, m_tick}) begin
                bad++;
                $display("FAIL oneshot cyc=%0d got=%b want=%b", i, {count, running, expire, over, obs_tick},
                         {m_count, m_run, m_expire, m_over, m_tick});
            end
        end
        total++;
        if (ticks != 3 || exps != 1 || count !== 4'd0 || over !== 1'b1 || running !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_end ticks=%0d exps=%0d count=%0d over=%b run=%b want 3 1 0 1 0",
                     ticks, exps, count, over, running);
        end
    endtask

    task automatic test_pause();
        int ticks = 0, exps = 0, pcyc = 0;
        logic p;
        drive(1, 5, 0, 0, 0);
        for (int i = 0; i < 60; i++) begin
            p = (ticks >= 2) && (pcyc < 10);
            if (p) pcyc++;
            drive(0, 5, 1, p, 0);
            ticks += int'(obs_tick);
            exps  += int'(expire);
            total++;
            if ({count, running, expire, over, obs_tick} !== {m_count, m_run, m_expire, m_over, m_tick}) begin
                bad++;
                $display("FAIL pause cyc=%0d got=%b want=%b", i, {count, running, expire, over, obs_tick},
                         {m_count, m_run, m_expire, m_over, m_tick});
            end
            if (p) begin
                total++;
                if (count !== 4'd3 || obs_tick !== 1'b0) begin
                    bad++;
                    $display("FAIL pause_frozen cyc=%0d count=%0d tick=%b want 3 0", i, count, obs_tick);
                end
            end
        end
        total++;
        if (ticks != 5 || exps != 1) begin
            bad++;
            $display("FAIL pause_totals ticks=%0d exps=%0d want 5 1", ticks, exps);
        end
    endtask

    task automatic test_auto_reload();
        int exps = 0;
        drive(1, 2, 0, 0, 1);
        drive(0, 2, 1, 0, 1);
        for (int i = 0; i < 30; i++) begin
            drive(0, 2, 0, 0, 1);
            exps += int'(expire);
            total++;
            if ({count, running, expire, over, obs_tick} !== {m_count, m_run, m_expire, m_over, m_tick}) begin
                bad++;
                $display("FAIL autoreload cyc=%0d got=%b want=%b", i, {count, running, expire, over, obs_tick},
                         {m_count, m_run, m_expire, m_over, m_tick});
            end
            total++;
            if (running !== 1'b1 || count === 4'd0) begin
                bad++;
                $display("FAIL autoreload_run cyc=%0d running=%b count=%0d want running=1 count!=0",
                         i, running, count);
            end
        end
        total++;
        if (exps < 3 || over !== 1'b1) begin
            bad++;
            $display("FAIL autoreload_exp exps=%0d over=%b want >=3 1", exps, over);
        end
    endtask

    task automatic test_zero_load();
        int ticks = 0, exps = 0;
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 0, 0);
            ticks += int'(obs_tick);
            exps  += int'(expire);
            total++;
            if ({count, running, expire, over, obs_tick} !== {m_count, m_run, m_expire, m_over, m_tick}) begin
                bad++;
                $display("FAIL zero cyc=%0d got=%b want=%b", i, {count, running, expire, over, obs_tick},
                         {m_count, m_run, m_expire, m_over, m_tick});
            end
        end
        total++;
        if (ticks != 0 || exps != 1 || over !== 1'b1) begin
            bad++;
            $display("FAIL zero_totals ticks=%0d exps=%0d over=%b want 0 1 1", ticks, exps, over);
        end
    endtask

    task automatic test_load_vs_tick();
        logic found = 0;
        drive(1, 6, 0, 0, 0);
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_run && m_count == 4 && m_left == 1) found = 1;
            else drive(0, 6, 1, 0, 0);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL loadtick_reach count=%0d want 4 with pending tick", count);
        end else begin
            drive(1, 9, 1, 0, 0);
            total++;
            if (count !== 4'd9 || over !== 1'b0 || running !== 1'b0 || expire !== 1'b0 || obs_tick !== 1'b1) begin
                bad++;
                $display("FAIL loadtick count=%0d over=%b run=%b exp=%b tick=%b want 9 0 0 0 1",
                         count, over, running, expire, obs_tick);
            end
        end
        drive(1, 7, 0, 0, 0);
        repeat (6) drive(0, 7, 1, 0, 0);
        #3 rst = 1'b1;
        #1;
        total++;
        if ({count, running, tick, expire, over} !== '0) begin
            bad++;
            $display("FAIL async_reset got=%b want=0", {count, running, tick, expire, over});
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic          l, s, p, ar;
        logic [CW-1:0] lv;
        ar = 0;
        lv = 0;
        for (int i = 0; i < 1500; i++) begin
            l = ($urandom_range(0, 49) == 0);
            if (l) begin
                lv = CW'($urandom_range(0, 15));
                ar = ($urandom_range(0, 1) == 1);
            end
            s = ($urandom_range(0, 9) < 7);
            p = ($urandom_range(0, 7) == 0);
            drive(l, lv, s, p, ar);
            total++;
            if ({count, running, expire, over, obs_tick} !== {m_count, m_run, m_expire, m_over, m_tick}) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, {count, running, expire, over, obs_tick},
                         {m_count, m_run, m_expire, m_over, m_tick});
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_oneshot();
        test_pause();
        test_auto_reload();
        test_zero_load();
        test_load_vs_tick();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
